// File: rtl/reaction_pkg.sv
// reaction_pkg: shared constants for the reaction-timer design.
//   CLK_HZ / DEBOUNCE_MS / HOLD_MS  : board timing inputs
//   DEBOUNCE_CYCLES_DEF / HOLD_CYCLES_DEF : derived cycle counts
//   BTN_START / BTN_REACT           : button channel indices on ui_in
//   btn_evt_t                       : per-channel conditioned outputs
//   cnt_w()                         : counter width helper (min 1 bit)
package reaction_pkg;

  localparam int CLK_HZ      = 10_000_000;
  localparam int DEBOUNCE_MS = 5;
  localparam int HOLD_MS     = 1000;

  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int HOLD_CYCLES_DEF     = (CLK_HZ / 1000) * HOLD_MS;

  localparam int BTN_START = 0;
  localparam int BTN_REACT = 1;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
    logic hold;
  } btn_evt_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// btn_channel: one button lane -- 2-flop synchroniser, debouncer, edge
// pulses and long-press detector.
//   clk, reset  : clock, async active-high reset
//   btn_raw_i   : raw asynchronous button level
//   evt_o       : registered level / rise / fall / hold
module btn_channel
  import reaction_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     btn_raw_i,
  output btn_evt_t evt_o
);

  localparam int DBW = cnt_w(DEBOUNCE_CYCLES);
  localparam int HW  = cnt_w(HOLD_CYCLES + 1);

  localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_PRE = HW'(HOLD_CYCLES - 1);

  logic [1:0]     sync_q;
  logic           sync;
  logic           stable_q, stable_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic           hold_q, hold_d;

  assign sync = sync_q[1];

  always_comb begin
    stable_d   = stable_q;
    db_cnt_d   = '0;
    hold_cnt_d = '0;
    hold_d     = 1'b0;

    // Any sample agreeing with the accepted level restarts the count, so
    // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples flips it.
    if (sync != stable_q) begin
      if (db_cnt_q == DB_LAST) stable_d = ~stable_q;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end

    rise_d = ~stable_q &  stable_d;
    fall_d =  stable_q & ~stable_d;

    // Saturating press timer; a release landing on the threshold edge
    // suppresses the hold pulse.
    if (stable_q) begin
      hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
      hold_d     = (hold_cnt_q == HOLD_PRE) & stable_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q     <= '0;
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn_raw_i};
      stable_q   <= stable_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      hold_q     <= hold_d;
    end
  end

  assign evt_o = '{level: stable_q, rise: rise_q, fall: fall_q, hold: hold_q};

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: conditions N_BTN raw push-buttons into clean levels
// and single-cycle press / release / long-press pulses. At the chip top,
// start_btn = btn_rise[BTN_START], react_btn = btn_rise[BTN_REACT].
//   clk, reset : clock, async active-high reset
//   btn_raw    : raw asynchronous button levels (active-high)
//   btn_level  : debounced level
//   btn_rise   : one-cycle pulse on accepted press
//   btn_fall   : one-cycle pulse on accepted release
//   btn_hold   : one-cycle pulse once a press lasts HOLD_CYCLES
module button_conditioner
  import reaction_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_rise,
  output logic [N_BTN-1:0] btn_fall,
  output logic [N_BTN-1:0] btn_hold
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be >= 1");
  end

  btn_evt_t evt [N_BTN];

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_raw_i(btn_raw[i]),
      .evt_o    (evt[i])
    );

    assign btn_level[i] = evt[i].level;
    assign btn_rise[i]  = evt[i].rise;
    assign btn_fall[i]  = evt[i].fall;
    assign btn_hold[i]  = evt[i].hold;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw push-button inputs (`ui_in[0]` start, `ui_in[1]` react) before they reach `reaction_fsm`. Each channel is synchronised, debounced and edge-detected, producing a clean level, single-cycle press/release pulses and a long-press pulse. It sits between the top-level `ui_in` pins and the FSM's `start_btn`/`react_btn` inputs. It replaces the current direct wiring, so the FSM never sees metastable or bouncing inputs.

## Interface
Parameters:
- `N_BTN`, 2: number of button channels.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a change (5 ms at 10 MHz); must be ≥1.
- `HOLD_CYCLES`, 10000000: pressed cycles before `btn_hold` fires (1 s at 10 MHz); must be ≥1.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `btn_raw` in N_BTN: raw asynchronous button levels, active-high.
- `btn_level` out N_BTN: debounced level.
- `btn_rise` out N_BTN: one-cycle pulse on accepted press.
- `btn_fall` out N_BTN: one-cycle pulse on accepted release.
- `btn_hold` out N_BTN: one-cycle pulse when a press has lasted HOLD_CYCLES.

## Operation
- Channels are fully independent and identical.
- Synchroniser: two flops per channel, producing `sync`. Reset value 0.
- Debounce state: `stable` (drives `btn_level`) and `db_cnt`. The counter width is clog2(DEBOUNCE_CYCLES), with a minimum of 1 bit.
  - `sync == stable`: `db_cnt` is cleared to 0.
  - `sync != stable` and `db_cnt < DEBOUNCE_CYCLES-1`: `db_cnt` increments.
  - `sync != stable` and `db_cnt == DEBOUNCE_CYCLES-1`: `stable` toggles and `db_cnt` is cleared.
  - A bounce back to the old level before acceptance restarts the count from 0.
- Edge pulses: `btn_rise`/`btn_fall` are registered. They assert in the same cycle `btn_level` first shows the new value, for exactly one cycle.
- Hold: `hold_cnt` (width clog2(HOLD_CYCLES+1)) runs while `stable == 1` and is cleared while `stable == 0`.
  - `btn_hold` pulses once, in the cycle `hold_cnt` reaches HOLD_CYCLES.
  - `hold_cnt` then saturates, so there is no repeat until a release followed by a new press.
- Edge cases:
  - Release and hold threshold in the same cycle: the release wins and `btn_hold` is not emitted.
  - Simultaneous events on different channels are all reported in the same cycle.
- Reset: all flops clear asynchronously, so all outputs are 0.
  - If a button is held through reset deassertion, it is treated as a new press: `btn_rise` fires after the normal latency.
  - Reset mid-debounce discards the partial count.

## Timing
- Input latency: a `btn_raw` change that stays steady, first sampled at edge t, appears on `btn_level`/`btn_rise`/`btn_fall` after edge t+1+DEBOUNCE_CYCLES. That is 2 synchroniser cycles plus DEBOUNCE_CYCLES−1 counting cycles, with the toggle on the final edge.
- `btn_hold` asserts HOLD_CYCLES cycles after `btn_rise`.
- All outputs are registered; there are no combinational paths from `btn_raw`.
- Minimum accepted pulse width is DEBOUNCE_CYCLES cycles. Shorter glitches are ignored entirely.
- Top-level integration: `start_btn = btn_rise[0]`, `react_btn = btn_rise[1]`.

## Structure
- Shared package `reaction_pkg` holds:
  - `CLK_HZ`
  - `DEBOUNCE_MS`
  - derived defaults for DEBOUNCE_CYCLES and HOLD_CYCLES
  - button index constants `BTN_START = 0`, `BTN_REACT = 1`
- Sub-module `btn_channel`: one synchroniser, debouncer and hold counter. It is instantiated N_BTN times by a generate loop in `button_conditioner`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
- Clean press: `btn_raw[0]` 0→1 sampled at edge 10 → `btn_level[0]` high and `btn_rise[0]` high for one cycle after edge 15. There are no other pulses.
- Bounce: `btn_raw[1]` toggles 1,0,1,0 every 2 cycles, then stays 1 → exactly one `btn_rise[1]`, 5 cycles after the final 0→1 sample. `btn_level[1]` never glitches.
- Sub-threshold glitch: a 3-cycle high pulse on `btn_raw[0]` → no output activity.
- Long press: hold `btn_raw[0]` for 20 cycles after acceptance → `btn_hold[0]` pulses once, 8 cycles after `btn_rise[0]`. Release → `btn_fall[0]` after 5 cycles.
- Simultaneous press: both raw bits rise at the same edge → `btn_rise` = 2'b11 in the same cycle.
- Reset mid-operation: assert `reset` while both buttons are held and mid-hold-count → all outputs 0 immediately. After deassertion with buttons still held → `btn_rise` = 2'b11 after 5 cycles.
